fp_clip_sequencer: RTL and testbench

- Initiator for the multi-cycle floating-point compare unit (clk_en / dataa / datab / result / done custom-op interface); that unit is the responder.
- Accepts IEEE-754 single-precision audio samples over a valid/ready stream.
- Issues up to two compares per sample (sample vs +T, sample vs -T) and emits the hard-clipped sample.
- Sits between the effects pipeline's sample source and the output stage; forms the hard-clip/distortion path.

---
 rtl/fp_clip_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fp_clip_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_clip_sequencer.sv
// fp_clip_sequencer
// Hard-clip stage for IEEE-754 single-precision audio samples. For each
// accepted sample S it drives an external multi-cycle compare unit: first
// S against +|T|, then, if that did not clip, S against -|T|. The result
// is S, +|T| or -|T|, presented on a valid/ready output.
//
// Ports
//   clock, reset_n             system clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  sample input stream
//   thr                        clip threshold; only its magnitude is used
//   out_valid/out_ready        result stream handshake
//   out_data/out_clipped       clipped sample, and whether it was replaced
//   cmp_clk_en                 compare-unit enable, high for a whole compare
//   cmp_dataa/cmp_datab        compare operands
//   cmp_result/cmp_done        compare flags {alb, agb, aeb} and their strobe
//   error                      sticky flag: a compare was abandoned
module fp_clip_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] thr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_clipped,
    output logic        cmp_clk_en,
    output logic [31:0] cmp_dataa,
    output logic [31:0] cmp_datab,
    input  logic [31:0] cmp_result,
    input  logic        cmp_done,
    output logic        error
);
    // state  | meaning
    // IDLE   | waiting for a sample, in_ready high
    // CMP_HI | compare S against +|T|
    // GAP    | one cycle with cmp_clk_en low so the compare unit re-arms
    // CMP_LO | compare S against -|T|
    // OUT    | result held on out_data until out_ready
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMP_HI = 3'd1,
        GAP    = 3'd2,
        CMP_LO = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The counter holds the number of compare cycles already spent without
    // cmp_done; the compare is abandoned at the end of cycle TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [31:0]   s_q, s_nxt;
    logic [31:0]   p_q, p_nxt;
    logic [31:0]   n_q, n_nxt;
    logic [31:0]   od_nxt;
    logic          oc_nxt;
    logic          err_nxt;
    logic          cmp_active;
    logic          cmp_timeout;

    assign cmp_active  = (state_q == CMP_HI) || (state_q == CMP_LO);
    // cmp_done in the last allowed cycle wins over the timeout.
    assign cmp_timeout = cmp_active && !cmp_done && (cnt_q == CNT_LAST);

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign cmp_clk_en = cmp_active;
    assign cmp_dataa  = cmp_active ? s_q : 32'h0;
    assign cmp_datab  = (state_q == CMP_HI) ? p_q :
                        (state_q == CMP_LO) ? n_q : 32'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s_q         <= 32'h0;
            p_q         <= 32'h0;
            n_q         <= 32'h0;
            out_data    <= 32'h0;
            out_clipped <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            s_q         <= s_nxt;
            p_q         <= p_nxt;
            n_q         <= n_nxt;
            out_data    <= od_nxt;
            out_clipped <= oc_nxt;
            error       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        s_nxt     = s_q;
        p_nxt     = p_q;
        n_nxt     = n_q;
        od_nxt    = out_data;
        oc_nxt    = out_clipped;
        err_nxt   = error;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_nxt     = in_data;
                    p_nxt     = {1'b0, thr[30:0]};
                    n_nxt     = {1'b1, thr[30:0]};
                    cnt_nxt   = '0;
                    state_nxt = CMP_HI;
                end
            end
            CMP_HI: begin
                if (cmp_done) begin
                    cnt_nxt = '0;
                    if (cmp_result[1]) begin
                        od_nxt    = p_q;
                        oc_nxt    = 1'b1;
                        state_nxt = OUT;
                    end else begin
                        state_nxt = GAP;
                    end
                end else if (cmp_timeout) begin
                    err_nxt   = 1'b1;
                    od_nxt    = s_q;
                    oc_nxt    = 1'b0;
                    state_nxt = OUT;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            GAP: begin
                cnt_nxt   = '0;
                state_nxt = CMP_LO;
            end
            CMP_LO: begin
                if (cmp_done) begin
                    if (cmp_result[2]) begin
                        od_nxt = n_q;
                        oc_nxt = 1'b1;
                    end else begin
                        od_nxt = s_q;
                        oc_nxt = 1'b0;
                    end
                    state_nxt = OUT;
                end else if (cmp_timeout) begin
                    err_nxt   = 1'b1;
                    od_nxt    = s_q;
                    oc_nxt    = 1'b0;
                    state_nxt = OUT;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp_clip_sequencer.sv
// Self-checking bench for fp_clip_sequencer. A behavioural compare-unit
// responder answers with per-compare delays chosen by the stimulus; a
// timeline model predicts every output from the sample, threshold and delays.
module tb_fp_clip_sequencer;
    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] thr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_clipped;
    logic        cmp_clk_en;
    logic [31:0] cmp_dataa;
    logic [31:0] cmp_datab;
    logic [31:0] cmp_result;
    logic        cmp_done;
    logic        error;

    always #5 clock = ~clock;

    fp_clip_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .thr        (thr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_clipped(out_clipped),
        .cmp_clk_en (cmp_clk_en),
        .cmp_dataa  (cmp_dataa),
        .cmp_datab  (cmp_datab),
        .cmp_result (cmp_result),
        .cmp_done   (cmp_done),
        .error      (error)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // stimulus for the next clock edge
    logic        drv_valid, drv_ready;
    logic [31:0] drv_data, drv_thr;
    int          drv_d1, drv_d2;

    // timeline model of the current sample
    logic        m_busy, m_err, m_two, m_to, m_oc;
    logic [31:0] m_s, m_p, m_n, m_od;
    int          m_k, m_l1, m_tot, m_d1, m_d2;

    // responder
    logic rsp_active;
    int   rsp_cnt, rsp_d, rsp_idx;

    // observations of the DUT for the directed literal checks
    logic        prev_en, accepted, obs_oc;
    int          acc_cyc, obs_rise, obs_en, obs_gap, obs_lat;
    logic [31:0] obs_db0, obs_db1, obs_od_first, obs_od_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // IEEE single compare, returns {alb, agb, aeb}; NaN gives all zero.
    function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        int ka, kb;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 3'b000;
        ka = a[31] ? -int'({1'b0, a[30:0]}) : int'({1'b0, a[30:0]});
        kb = b[31] ? -int'({1'b0, b[30:0]}) : int'({1'b0, b[30:0]});
        return {ka < kb, ka > kb, ka == kb};
    endfunction

    // Expected result and timeline: a compare answered after d cycles takes
    // d+1 enable cycles; d >= TIMEOUT means it is abandoned after TIMEOUT.
    task automatic clip_ref(input logic [31:0] s, input logic [31:0] t, input int d1, input int d2,
                            output logic [31:0] od, output logic oc, output logic to,
                            output logic two, output int l1, output int tot);
        logic [2:0]  r;
        logic [31:0] p, n;
        int          l2;
        p   = {1'b0, t[30:0]};
        n   = {1'b1, t[30:0]};
        two = 1'b0;
        to  = 1'b0;
        l1  = (d1 >= TIMEOUT) ? TIMEOUT : d1 + 1;
        tot = l1;
        r   = fcmp(s, p);
        if (d1 >= TIMEOUT) begin
            od = s; oc = 1'b0; to = 1'b1;
        end else if (r[1]) begin
            od = p; oc = 1'b1;
        end else begin
            two = 1'b1;
            l2  = (d2 >= TIMEOUT) ? TIMEOUT : d2 + 1;
            tot = l1 + 1 + l2;
            r   = fcmp(s, n);
            if (d2 >= TIMEOUT) begin
                od = s; oc = 1'b0; to = 1'b1;
            end else if (r[2]) begin
                od = n; oc = 1'b1;
            end else begin
                od = s; oc = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic        exp_ov, exp_en;
        logic [31:0] rnd;
        logic [2:0]  r;
        @(negedge clock);
        exp_ov = m_busy && (m_k >= m_tot);
        exp_en = m_busy && !exp_ov && ((m_k < m_l1) || (m_two && m_k > m_l1));
        chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("cmp_clk_en", {31'b0, cmp_clk_en}, {31'b0, exp_en});
        chk("error", {31'b0, error}, {31'b0, m_err});
        if (exp_en) begin
            chk("cmp_dataa", cmp_dataa, m_s);
            chk("cmp_datab", cmp_datab, (m_k < m_l1) ? m_p : m_n);
        end
        if (exp_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_clipped", {31'b0, out_clipped}, {31'b0, m_oc});
        end

        if (cmp_clk_en && !prev_en) begin
            if (obs_rise == 0) obs_db0 = cmp_datab;
            else               obs_db1 = cmp_datab;
            obs_rise++;
        end
        if (cmp_clk_en) obs_en++;
        if (obs_rise == 1 && !cmp_clk_en && !out_valid && !in_ready) obs_gap++;
        if (out_valid) begin
            if (obs_lat < 0) begin
                obs_lat      = cyc - acc_cyc - 1;
                obs_od_first = out_data;
                obs_oc       = out_clipped;
            end
            obs_od_last = out_data;
        end
        prev_en = cmp_clk_en;

        rnd = $urandom();
        if (cmp_clk_en) begin
            if (!rsp_active) begin
                rsp_active = 1'b1;
                rsp_cnt    = 0;
                rsp_d      = (rsp_idx == 0) ? m_d1 : m_d2;
                rsp_idx++;
            end else begin
                rsp_cnt++;
            end
            cmp_done   = (rsp_cnt == rsp_d);
            r          = fcmp(cmp_dataa, cmp_datab);
            cmp_result = cmp_done ? {rnd[31:3], r} : rnd;
        end else begin
            rsp_active = 1'b0;
            cmp_done   = ($urandom_range(0, 7) == 0);
            cmp_result = rnd;
        end

        in_valid  = drv_valid;
        in_data   = drv_data;
        thr       = drv_thr;
        out_ready = drv_ready;

        if (!m_busy) begin
            if (drv_valid) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_s     = drv_data;
                m_p     = {1'b0, drv_thr[30:0]};
                m_n     = {1'b1, drv_thr[30:0]};
                m_d1    = drv_d1;
                m_d2    = drv_d2;
                clip_ref(drv_data, drv_thr, drv_d1, drv_d2, m_od, m_oc, m_to, m_two, m_l1, m_tot);
                rsp_idx  = 0;
                acc_cyc  = cyc;
                accepted = 1'b1;
                obs_rise = 0;
                obs_en   = 0;
                obs_gap  = 0;
                obs_lat  = -1;
            end
        end else if (m_k >= m_tot) begin
            if (drv_ready) m_busy = 1'b0;
        end else begin
            if (m_k + 1 == m_tot && m_to) m_err = 1'b1;
            m_k++;
        end
        cyc++;
    endtask

    task automatic run_sample(input logic [31:0] s, input logic [31:0] t, input int d1, input int d2,
                              input int rdy_wait);
        int n, w;
        drv_valid = 1'b1;
        drv_data  = s;
        drv_thr   = t;
        drv_d1    = d1;
        drv_d2    = d2;
        drv_ready = 1'b0;
        accepted  = 1'b0;
        n = 0;
        while (!accepted && n < 200) begin
            cycle();
            n++;
        end
        // keep offering junk while busy; it must not be taken
        drv_data = $urandom();
        drv_thr  = $urandom();
        w = 0;
        while (m_busy && n < 200) begin
            if (m_k >= m_tot) begin
                drv_ready = (w >= rdy_wait);
                w++;
            end else begin
                drv_ready = 1'(($urandom_range(0, 1)));
            end
            cycle();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL sample_budget: sample %h still pending after %0d cycles, limit 200", s, n);
        end
        drv_valid = 1'b0;
    endtask

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r < 13) return $urandom_range(0, 4);
        if (r == 13) return TIMEOUT - 1;
        if (r == 14) return TIMEOUT;
        if (r == 15) return 99;
        return $urandom_range(5, 10);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, t, od;
        logic        oc, to, two;
        int          l1, tot, kind;

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'h0;
        thr        = 32'h0;
        out_ready  = 1'b0;
        cmp_done   = 1'b0;
        cmp_result = 32'h0;
        drv_valid  = 1'b0;
        drv_ready  = 1'b0;
        drv_data   = 32'h0;
        drv_thr    = 32'h0;
        drv_d1     = 0;
        drv_d2     = 0;
        m_busy     = 1'b0;
        m_err      = 1'b0;
        m_two      = 1'b0;
        m_to       = 1'b0;
        m_oc       = 1'b0;
        m_s = 0; m_p = 0; m_n = 0; m_od = 0;
        m_k = 0; m_l1 = 0; m_tot = 0; m_d1 = 0; m_d2 = 0;
        rsp_active = 1'b0; rsp_cnt = 0; rsp_d = 0; rsp_idx = 0;
        prev_en = 1'b0; accepted = 1'b0; obs_oc = 1'b0;
        acc_cyc = 0; obs_rise = 0; obs_en = 0; obs_gap = 0; obs_lat = -1;
        obs_db0 = 0; obs_db1 = 0; obs_od_first = 0; obs_od_last = 0;

        // pin the reference model with hand-computed values
        clip_ref(32'h40000000, 32'h3F800000, 2, 0, od, oc, to, two, l1, tot);
        chk("model_hi_clip", od, 32'h3F800000);
        chk("model_hi_latency", 32'(tot), 32'd3);
        clip_ref(32'hC0000000, 32'hBF800000, 0, 0, od, oc, to, two, l1, tot);
        chk("model_lo_clip", od, 32'hBF800000);
        clip_ref(32'h7FC00000, 32'h3F800000, 0, 0, od, oc, to, two, l1, tot);
        chk("model_nan", {od[31:1], oc}, {31'h3FE00000, 1'b0});

        #3;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_clipped", {31'b0, out_clipped}, 32'd0);
        chk("rst_cmp_clk_en", {31'b0, cmp_clk_en}, 32'd0);
        chk("rst_cmp_dataa", cmp_dataa, 32'h0);
        chk("rst_cmp_datab", cmp_datab, 32'h0);
        chk("rst_error", {31'b0, error}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // high clip, done two cycles after enable
        run_sample(32'h40000000, 32'h3F800000, 2, 0, 0);
        chk("t1_latency", 32'(obs_lat), 32'd3);
        chk("t1_out_data", obs_od_first, 32'h3F800000);
        chk("t1_clipped", {31'b0, obs_oc}, 32'd1);
        chk("t1_compares", 32'(obs_rise), 32'd1);
        chk("t1_en_cycles", 32'(obs_en), 32'd3);

        // low clip through the gap cycle
        run_sample(32'hC0000000, 32'h3F800000, 1, 1, 0);
        chk("t2_compares", 32'(obs_rise), 32'd2);
        chk("t2_datab_hi", obs_db0, 32'h3F800000);
        chk("t2_datab_lo", obs_db1, 32'hBF800000);
        chk("t2_gap_cycles", 32'(obs_gap), 32'd1);
        chk("t2_out_data", obs_od_first, 32'hBF800000);
        chk("t2_clipped", {31'b0, obs_oc}, 32'd1);

        // negative threshold used as magnitude
        run_sample(32'h3F000000, 32'hBF800000, 0, 3, 0);
        chk("t3_datab_hi", obs_db0, 32'h3F800000);
        chk("t3_datab_lo", obs_db1, 32'hBF800000);
        chk("t3_out_data", obs_od_first, 32'h3F000000);
        chk("t3_clipped", {31'b0, obs_oc}, 32'd0);

        // equal to T, NaN, zero thresholds
        run_sample(32'h3F800000, 32'h3F800000, 1, 1, 0);
        chk("t4_eq_data", obs_od_first, 32'h3F800000);
        chk("t4_eq_clipped", {31'b0, obs_oc}, 32'd0);
        run_sample(32'h7FC00000, 32'h3F800000, 2, 2, 0);
        chk("t4_nan_data", obs_od_first, 32'h7FC00000);
        chk("t4_nan_clipped", {31'b0, obs_oc}, 32'd0);
        run_sample(32'h40400000, 32'h00000000, 0, 0, 0);
        chk("t4_zero_pos", obs_od_first, 32'h00000000);
        run_sample(32'hC0400000, 32'h80000000, 0, 0, 0);
        chk("t4_zero_neg", obs_od_first, 32'h80000000);

        // done on the last allowed cycle beats the timeout
        run_sample(32'h40000000, 32'h3F800000, TIMEOUT - 1, 0, 0);
        chk("t5_last_cycle_data", obs_od_first, 32'h3F800000);
        chk("t5_last_cycle_error", {31'b0, error}, 32'd0);
        chk("t5_last_cycle_en", 32'(obs_en), 32'd15);

        // dead responder
        run_sample(32'h3F000000, 32'h3F800000, 99, 0, 0);
        chk("t5_to_en_cycles", 32'(obs_en), 32'd15);
        chk("t5_to_data", obs_od_first, 32'h3F000000);
        chk("t5_to_clipped", {31'b0, obs_oc}, 32'd0);
        chk("t5_to_error", {31'b0, error}, 32'd1);
        run_sample(32'h40000000, 32'h3F800000, 1, 0, 0);
        chk("t5_after_data", obs_od_first, 32'h3F800000);
        chk("t5_after_error", {31'b0, error}, 32'd1);

        // output back-pressure with new samples offered
        run_sample(32'hC0000000, 32'h3F800000, 0, 0, 5);
        chk("t6_first", obs_od_first, 32'hBF800000);
        chk("t6_last", obs_od_last, 32'hBF800000);

        // reset in the middle of the low compare
        drv_valid = 1'b1; drv_data = 32'hC0000000; drv_thr = 32'h3F800000;
        drv_d1 = 1; drv_d2 = 10; drv_ready = 1'b0; accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_busy && m_two && m_k > m_l1 + 2) break;
            cycle();
            drv_valid = 1'b0;
        end
        chk("t7_in_lo_phase", {31'b0, cmp_clk_en}, 32'd1);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        cmp_done = 1'b0;
        #1;
        chk("t7_rst_clk_en", {31'b0, cmp_clk_en}, 32'd0);
        chk("t7_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t7_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t7_rst_error", {31'b0, error}, 32'd0);
        m_busy = 1'b0; m_err = 1'b0; rsp_active = 1'b0; prev_en = 1'b0;
        drv_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                drv_valid = 1'b0;
                drv_ready = 1'(($urandom_range(0, 1)));
                cycle();
            end
            t    = $urandom();
            kind = $urandom_range(0, 9);
            if (kind == 0) t = 32'h0;
            if (kind == 1) t = 32'h7FC00001;
            kind = $urandom_range(0, 7);
            case (kind)
                0: s = {1'b0, t[30:0]};
                1: s = {1'b1, t[30:0]};
                2: s = {$urandom_range(0, 1) == 1, 31'h7FC00000};
                3: s = {$urandom_range(0, 1) == 1, 31'h0};
                4: s = t + 32'($urandom_range(0, 4)) - 32'd2;
                default: s = $urandom();
            endcase
            run_sample(s, t, rand_delay(), rand_delay(), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
